// File: rtl/calc_pkg.sv
// Shared keycode constants and state types for the calculator keypad front end.
package calc_pkg;

  localparam logic [4:0] KEY_NULL      = 5'h00;
  localparam logic [4:0] KEY_CLEAR     = 5'h01;
  localparam logic [4:0] KEY_PLUS      = 5'h02;
  localparam logic [4:0] KEY_MUL       = 5'h03;
  localparam logic [4:0] KEY_EQUAL     = 5'h04;
  localparam logic [4:0] KEY_DIGIT_MSB = 5'h10;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_e;

  typedef enum logic [1:0] {DB_IDLE, DB_PRESS, DB_HELD, DB_REL} db_state_e;

  // Matrix index row*4+col: rows 0-3 are hex digits, row 4 holds the operators.
  function automatic logic [4:0] key_code(input logic [4:0] idx);
    if (!idx[4]) return KEY_DIGIT_MSB | {1'b0, idx[3:0]};
    case (idx[1:0])
      2'd0:    return KEY_CLEAR;
      2'd1:    return KEY_PLUS;
      2'd2:    return KEY_MUL;
      default: return KEY_EQUAL;
    endcase
  endfunction

endpackage

// File: rtl/keypad_column_scan.sv
// Row synchroniser, column dwell/drive and per-scan accumulation of closed keys.
module keypad_column_scan
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 5000
) (
  input  logic      clock,
  input  logic      reset,
  input  logic [4:0] row,
  output logic [3:0] col,
  output logic      scan_done,
  output scan_res_e scan_result,
  output logic [4:0] scan_idx
);

  localparam int DW = $clog2(SCAN_DIV) + 1;

  logic [4:0]    r_sync1, r_sync2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  logic [1:0]    r_cnt;
  logic [4:0]    r_idx;
  logic          r_done;
  scan_res_e     r_result;
  logic [4:0]    r_scan_idx;

  logic          w_last;
  logic [1:0]    w_cnt;
  logic [4:0]    w_idx;

  assign w_last = (r_dwell == DW'(SCAN_DIV - 1));

  // Fold this column's rows into the running scan; later rows win the index.
  always_comb begin
    w_cnt = r_cnt;
    w_idx = r_idx;
    for (int r = 0; r < 5; r++) begin
      if (!r_sync2[r]) begin
        w_cnt = (w_cnt == 2'd2) ? 2'd2 : w_cnt + 2'd1;
        w_idx = 5'(r * 4) + {3'b000, r_col_idx};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_dwell    <= '0;
      r_col_idx  <= '0;
      r_col      <= 4'b1110;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_result   <= NONE;
      r_scan_idx <= '0;
    end else begin
      r_sync1 <= row;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      if (w_last) begin
        r_dwell   <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        r_col     <= {r_col[2:0], r_col[3]};
        if (r_col_idx == 2'd3) begin
          r_done     <= 1'b1;
          r_result   <= (w_cnt == 2'd0) ? NONE : (w_cnt == 2'd1) ? SINGLE : MULTI;
          r_scan_idx <= w_idx;
          r_cnt      <= '0;
          r_idx      <= '0;
        end else begin
          r_cnt <= w_cnt;
          r_idx <= w_idx;
        end
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  assign col         = r_col;
  assign scan_done   = r_done;
  assign scan_result = r_result;
  assign scan_idx    = r_scan_idx;

endmodule

// File: rtl/keypad_scanner.sv
// 5x4 keypad scanner: debounces whole-matrix scans and emits one newKey pulse per press.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] row,
  output logic [3:0] col,
  output logic       newKey,
  output logic [4:0] keycode
);

  localparam int CW = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_SCANS);

  logic      w_done;
  scan_res_e w_res;
  logic [4:0] w_idx;

  keypad_column_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .scan_done   (w_done),
    .scan_result (w_res),
    .scan_idx    (w_idx)
  );

  db_state_e     r_state, w_state;
  logic [4:0]    r_cand, w_cand;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [CW-1:0] r_rel, w_rel;
  logic          r_newkey, w_newkey;
  logic [4:0]    r_keycode, w_keycode;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= DB_IDLE;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_rel     <= '0;
      r_newkey  <= 1'b0;
      r_keycode <= KEY_NULL;
    end else begin
      r_state   <= w_state;
      r_cand    <= w_cand;
      r_cnt     <= w_cnt;
      r_rel     <= w_rel;
      r_newkey  <= w_newkey;
      r_keycode <= w_keycode;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cand    = r_cand;
    w_cnt     = r_cnt;
    w_rel     = r_rel;
    w_newkey  = 1'b0;
    w_keycode = r_keycode;
    if (w_done) begin
      case (r_state)
        DB_IDLE: if (w_res == SINGLE) begin
          w_cand = w_idx;
          w_cnt  = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            w_state   = DB_HELD;
            w_newkey  = 1'b1;
            w_keycode = key_code(w_idx);
          end else begin
            w_state = DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (w_res == SINGLE && w_idx == r_cand) begin
            w_cnt = (r_cnt == DB_MAX) ? r_cnt : r_cnt + 1'b1;
            if ((r_cnt + 1'b1) >= DB_MAX) begin
              w_state   = DB_HELD;
              w_newkey  = 1'b1;
              w_keycode = key_code(r_cand);
            end
          end else begin
            w_state = DB_IDLE;
            w_cnt   = '0;
          end
        end
        DB_HELD: if (w_res == NONE) begin
          w_rel = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            w_state   = DB_IDLE;
            w_keycode = KEY_NULL;
            w_cnt     = '0;
            w_rel     = '0;
          end else begin
            w_state = DB_REL;
          end
        end
        DB_REL: begin
          // Any closed key seen during release debounce counts as still held.
          if (w_res == NONE) begin
            w_rel = (r_rel == DB_MAX) ? r_rel : r_rel + 1'b1;
            if ((r_rel + 1'b1) >= DB_MAX) begin
              w_state   = DB_IDLE;
              w_keycode = KEY_NULL;
              w_cnt     = '0;
              w_rel     = '0;
            end
          end else begin
            w_state = DB_HELD;
            w_rel   = '0;
          end
        end
        default: w_state = DB_IDLE;
      endcase
    end
  end

  assign newKey  = r_newkey;
  assign keycode = r_keycode;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a passive key-matrix model.
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] row;
  logic [3:0] col;
  logic       newKey;
  logic [4:0] keycode;

  logic [4:0][3:0] keys;
  int         n_vec = 0;
  int         n_err = 0;
  int         pulses = 0;
  logic [4:0] last_code = 5'h00;
  int         base;
  logic [3:0] exp_col;
  logic       found;
  logic [4:0] got_code;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .newKey  (newKey),
    .keycode (keycode)
  );

  always #5 clock = ~clock;

  always_comb begin
    row = '1;
    for (int r = 0; r < 5; r++) row[r] = ~|(keys[r] & ~col);
  end

  always @(negedge clock) begin
    if (newKey) begin
      pulses    <= pulses + 1;
      last_code <= keycode;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Leaves the bench on the negedge where reset is released (cycle 0 of a fresh scan).
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
  endtask

  task automatic press_release(input int r, input int c, input int scans, input logic [4:0] code);
    base = pulses;
    keys[r][c] = 1'b1;
    wait_cyc(scans * 16);
    chk("press_count", pulses - base, 1);
    chk("press_code", last_code, code);
    chk("held_keycode", keycode, code);
    keys[r][c] = 1'b0;
    wait_cyc(16);
    chk("rel_hold_keycode", keycode, code);
    wait_cyc(48);
    chk("rel_keycode", keycode, 5'h00);
    chk("rel_count", pulses - base, 1);
  endtask

  initial begin
    reset = 1'b0;
    keys  = '0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(7);
    #2 reset = 1'b0;
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_newkey", newKey, 0);
    chk("rst_keycode", keycode, 5'h00);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      exp_col = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
      chk("col_walk", col, exp_col);
      @(negedge clock);
    end

    press_release(0, 1, 10, 5'h11);
    press_release(4, 2, 6, 5'h03);
    press_release(2, 3, 6, 5'h1B);

    // Bounce on (1,1): column-1 samples land on closed, open, open, closed, open.
    do_reset();
    base = pulses;
    wait_cyc(4);
    for (int m = 0; m < 80; m++) begin
      keys[1][1] = ((m / 3) % 2 == 0);
      @(negedge clock);
    end
    keys[1][1] = 1'b0;
    wait_cyc(64);
    chk("bounce_count", pulses - base, 0);
    chk("bounce_keycode", keycode, 5'h00);

    base = pulses;
    keys[1][1] = 1'b1;
    keys[2][2] = 1'b1;
    wait_cyc(64);
    chk("multi_count", pulses - base, 0);
    chk("multi_keycode", keycode, 5'h00);
    keys[1][1] = 1'b0;
    wait_cyc(96);
    chk("multi_rel_count", pulses - base, 1);
    chk("multi_rel_code", last_code, 5'h1A);
    keys[2][2] = 1'b0;
    wait_cyc(64);
    chk("multi_end_keycode", keycode, 5'h00);

    // Reset lands between the first and second matching scan of (0,3).
    do_reset();
    base = pulses;
    keys[0][3] = 1'b1;
    wait_cyc(24);
    reset = 1'b0;
    #1;
    chk("db_rst_count", pulses - base, 0);
    chk("db_rst_newkey", newKey, 0);
    chk("db_rst_keycode", keycode, 5'h00);
    chk("db_rst_col", col, 4'b1110);
    wait_cyc(3);
    reset = 1'b1;
    found    = 1'b0;
    got_code = 5'h00;
    for (int i = 1; i <= 51; i++) begin
      @(posedge clock);
      #1;
      if (newKey && !found) begin
        found    = 1'b1;
        got_code = keycode;
      end
    end
    chk("redb_found", found, 1);
    chk("redb_code", got_code, 5'h13);
    wait_cyc(64);
    chk("redb_count", pulses - base, 1);
    keys[0][3] = 1'b0;
    wait_cyc(64);
    chk("redb_rel_keycode", keycode, 5'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
